alu_stream: RTL
===============

// Module: alu_stream
// PURPOSE
//   Parametrised streaming ALU, successor to the 2-bit-opcode handshake ALU.
//   8 operations, status flags, registered compute stage feeding a result FIFO.
//   Valid/ready on both sides; full throughput under backpressure.
//   Sits between an operand producer and a result consumer in the datapath.
// PARAMETERS
//   WIDTH       8   operand/result width in bits (>=4)
//   FIFO_DEPTH  4   result FIFO entries (power of 2, >=2)
// PORTS
//   i_CLK     in   1                 system clock, rising edge
//   i_RST     in   1                 asynchronous reset, active-high
//   i_arg0    in   WIDTH             operand A (two's complement for signed ops)
//   i_arg1    in   WIDTH             operand B / shift amount
//   i_oper    in   3                 opcode
//   i_VALID   in   1                 operands/opcode valid
//   o_READY   out  1                 block accepts operands this cycle
//   o_VALID   out  1                 o_Y/o_FLAGS valid
//   i_READY   in   1                 consumer accepts result this cycle
//   o_Y       out  WIDTH             result
//   o_FLAGS   out  4                 {C,V,Z,N}
//   o_COUNT   out  $clog2(DEPTH)+1   results in flight (stage + FIFO)
// BEHAVIOUR
//   Reset: async; all outputs 0 except o_READY=1 once i_RST deasserts; in-flight data dropped.
//   Accept when i_VALID&&o_READY at posedge; otherwise inputs are not sampled.
//   o_READY = (o_COUNT < FIFO_DEPTH); registered count, no comb path from i_READY.
//   Pipeline: accept at edge k -> stage reg; FIFO write at edge k+1; o_VALID high after k+1.
//   Latency 2 cycles; throughput 1 result/cycle while i_READY=1.
//   Output: FIFO head shown first-word-fall-through; o_Y/o_FLAGS held stable while o_VALID&&!i_READY.
//   Pop on o_VALID&&i_READY; push+pop same cycle keeps count; pointers wrap mod FIFO_DEPTH.
//   Results leave in acceptance order; no drop, no duplication.
//   Opcodes: 000 ADD  001 SUB(A-B)  010 AND  011 OR  100 XOR
//            101 SHL  110 SRA (arith right)  111 CMP (Y=1 if A<B signed else 0)
//   Shift amount = i_arg1[$clog2(WIDTH)-1:0]; amount>=WIDTH -> SHL gives 0, SRA sign-fills.
//   Flags: C = carry out (ADD), borrow (SUB/CMP), last bit shifted out (SHL/SRA, 0 if amt 0).
//          V = signed overflow of ADD/SUB/CMP-difference; 0 for logic/shift ops.
//          Z = (o_Y==0); N = o_Y[WIDTH-1]. Logic ops: C=V=0.
//   CMP: Y per table; C,V from A-B; Z,N from Y.
//   Arithmetic internally WIDTH+1 bits; o_Y is low WIDTH bits (wraps) unless saturation on.
// CONFIGURATION
//   ALU_SAT_EN defined: ADD/SUB signed-saturate on overflow to 2^(W-1)-1 or -2^(W-1);
//     V still reports overflow, C computed from unsaturated sum; Z,N from saturated Y.
//   ALU_SAT_EN undefined: ADD/SUB wrap modulo 2^WIDTH; no saturation logic synthesised.
// TESTING (WIDTH=8, FIFO_DEPTH=4, i_READY=1 unless stated)
//   ADD 10+5 -> o_Y=0x0F, FLAGS=0000, o_VALID 2 cycles after accept.
//   ADD 127+1 -> no SAT: o_Y=0x80, V=1,N=1; ALU_SAT_EN: o_Y=0x7F, V=1,N=0.
//   SUB 50-50 -> o_Y=0x00, Z=1,C=0,V=0; CMP -3,2 -> o_Y=0x01, C=1.
//   AND 0xAA,0x0F -> 0x0A; SHL 0x03 by 1 -> 0x06,C=0; SRA 0x81 by 1 -> 0xC0,C=1.
//   i_READY=0, 6 back-to-back ops -> 4 accepted, o_READY=0, o_COUNT=4;
//     release i_READY -> 4 results in order, then remaining 2 accepted and delivered.
//   i_RST pulse mid-stream with 3 buffered -> o_VALID=0, o_COUNT=0 immediately; none delivered.

Source files
------------

// File: rtl/alu_stream.sv
// Streaming 8-op ALU: registered compute stage feeding a first-word-fall-through result FIFO.
// Optional build macro ALU_SAT_EN enables signed saturation of ADD/SUB results.
module alu_stream #(
  parameter int WIDTH      = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          i_CLK,
  input  logic                          i_RST,
  input  logic [WIDTH-1:0]              i_arg0,
  input  logic [WIDTH-1:0]              i_arg1,
  input  logic [2:0]                    i_oper,
  input  logic                          i_VALID,
  output logic                          o_READY,
  output logic                          o_VALID,
  input  logic                          i_READY,
  output logic [WIDTH-1:0]              o_Y,
  output logic [3:0]                    o_FLAGS,
  output logic [$clog2(FIFO_DEPTH):0]   o_COUNT
);

  localparam int AW = $clog2(WIDTH);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_SHL = 3'b101,
    OP_SRA = 3'b110,
    OP_CMP = 3'b111
  } op_e;

  // flags = {C, V, Z, N}
  typedef struct packed {
    logic [3:0]       flags;
    logic [WIDTH-1:0] y;
  } res_t;

  op_e              op;
  logic [AW-1:0]    amt;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [WIDTH:0]   shl_full;
  logic [WIDTH:0]   sra_full;
  logic             add_ovf;
  logic             sub_ovf;
  logic [WIDTH-1:0] y;
  logic             c;
  logic             v;

  logic             accept;
  logic             pop;
  logic             stage_vld;
  res_t             stage_res;
  res_t             mem [FIFO_DEPTH];
  res_t             head;
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    fifo_cnt;

  assign op  = op_e'(i_oper);
  assign amt = i_arg1[AW-1:0];

  // Subtraction is done on sign-extended operands, so bit WIDTH is the sign of the exact
  // difference: it serves as the borrow for SUB/CMP and directly as the CMP result.
  assign sum     = {1'b0, i_arg0} + {1'b0, i_arg1};
  assign diff    = {i_arg0[WIDTH-1], i_arg0} - {i_arg1[WIDTH-1], i_arg1};
  assign add_ovf = (i_arg0[WIDTH-1] == i_arg1[WIDTH-1]) && (sum[WIDTH-1] != i_arg0[WIDTH-1]);
  assign sub_ovf = diff[WIDTH] != diff[WIDTH-1];

  // One extra bit on each shifter catches the last bit shifted out; out-of-range amounts
  // fall out naturally as zero-fill (SHL) or sign-fill (SRA).
  assign shl_full = {1'b0, i_arg0} << amt;
  assign sra_full = $signed({i_arg0, 1'b0}) >>> amt;

`ifdef ALU_SAT_EN
  logic [WIDTH-1:0] sat_val;
  assign sat_val = {i_arg0[WIDTH-1], {(WIDTH-1){~i_arg0[WIDTH-1]}}};
`endif

  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    y = '0;
    c = 1'b0;
    v = 1'b0;
    case (op)
      OP_ADD: begin
        y = sum[WIDTH-1:0];
        c = sum[WIDTH];
        v = add_ovf;
`ifdef ALU_SAT_EN
        if (add_ovf) y = sat_val;
`endif
      end
      OP_SUB: begin
        y = diff[WIDTH-1:0];
        c = diff[WIDTH];
        v = sub_ovf;
`ifdef ALU_SAT_EN
        if (sub_ovf) y = sat_val;
`endif
      end
      OP_AND: y = i_arg0 & i_arg1;
      OP_OR:  y = i_arg0 | i_arg1;
      OP_XOR: y = i_arg0 ^ i_arg1;
      OP_SHL: begin
        y = shl_full[WIDTH-1:0];
        c = shl_full[WIDTH];
      end
      OP_SRA: begin
        y = sra_full[WIDTH:1];
        c = sra_full[0];
      end
      OP_CMP: begin
        y = WIDTH'(diff[WIDTH]);
        c = diff[WIDTH];
        v = sub_ovf;
      end
    endcase
  end

  // The stage can always drain into the FIFO: admission is capped on stage + FIFO occupancy.
  assign o_COUNT = fifo_cnt + CW'(stage_vld);
  assign o_READY = o_COUNT < CW'(FIFO_DEPTH);
  assign accept  = i_VALID && o_READY;
  assign o_VALID = fifo_cnt != '0;
  assign pop     = o_VALID && i_READY;

  // NOTE: state registers use non-blocking assignments so every register samples the
  // pre-edge values regardless of statement or block order.
  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      stage_vld <= 1'b0;
      stage_res <= '0;
    end else begin
      stage_vld <= accept;
      if (accept) begin
        stage_res.y     <= y;
        stage_res.flags <= {c, v, (y == '0), y[WIDTH-1]};
      end
    end
  end

  // NOTE: the storage array is deliberately not reset; occupancy and pointers are, and the
  // output mux below hides whatever stale contents the array holds.
  always_ff @(posedge i_CLK) begin
    if (stage_vld) mem[wr_ptr] <= stage_res;
  end

  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (stage_vld) wr_ptr <= wr_ptr + PW'(1);
      if (pop)       rd_ptr <= rd_ptr + PW'(1);
      fifo_cnt <= fifo_cnt + CW'(stage_vld) - CW'(pop);
    end
  end

  assign head    = mem[rd_ptr];
  assign o_Y     = o_VALID ? head.y     : '0;
  assign o_FLAGS = o_VALID ? head.flags : '0;

endmodule
